stage_decode: RTL and testbench
===============================

Name: stage_decode

Overview:
- Decode stage of the in-order RV32I pipeline, directly downstream of the fetch stage.
- Consumes the fetched instruction word, its PC and the valid flag.
- Produces a registered decode bundle for execute:
  - register addresses
  - sign-extended immediate
  - ALU op
  - control flags
- Detects load-use hazards and requests a fetch stall.
- Inserts bubbles on kill, hazard or invalid input.

Parameters:
- INSTR_SIZE, 32, instruction and PC width.
- REG_ADDR_W, 5, register index width.
- ALU_OP_W, 4, ALU operation code width.

Ports:
- clk  in  1  clock; all registers update on posedge.
- reset  in  1  asynchronous, active-high reset.
- pc_i  in  INSTR_SIZE  PC of instr_i.
- instr_i  in  INSTR_SIZE  fetched instruction word.
- instr_valid_i  in  1  instr_i/pc_i hold a real instruction.
- stall_i  in  1  downstream stall; hold the whole output bundle.
- kill_i  in  1  taken branch/jump; discard instruction in decode.
- hazard_stall_o  out  1  combinational load-use stall request to fetch.
- valid_o  out  1  output bundle is a real instruction.
- pc_o  out  INSTR_SIZE  registered PC.
- rs1_addr_o, rs2_addr_o, rd_addr_o  out  REG_ADDR_W each  register indices.
- imm_o  out  INSTR_SIZE  sign-extended immediate.
- alu_op_o  out  ALU_OP_W  ALU operation code: 0 ADD, 1 SUB, 2 SLL, 3 SLT, 4 SLTU, 5 XOR, 6 SRL, 7 SRA, 8 OR, 9 AND, 10 PASSB.
- funct3_o  out  3  raw funct3; branch condition and load/store size.
- use_imm_o  out  1  ALU operand B is imm_o.
- use_pc_o  out  1  ALU operand A is pc_o (AUIPC, JAL).
- reg_we_o, is_load_o, is_store_o, is_branch_o, is_jump_o  out  1 each  control flags.
- illegal_o  out  1  unsupported encoding.

Behaviour:
- Latency and reset
  - Decode is combinational; the bundle is registered, so latency is 1 cycle.
  - Reset (async assert) clears all registered outputs to 0, including valid_o, illegal_o and pc_o.
- Register update priority, evaluated each posedge:
  1. kill_i=1: write a bubble, even when stall_i=1.
  2. Else stall_i=1: hold every output register.
  3. Else instr_valid_i=0 or hazard_stall_o=1: write a bubble.
  4. Else: write the decoded bundle with valid_o=1.
- Bubble: valid_o, reg_we_o, is_load_o, is_store_o, is_branch_o, is_jump_o and illegal_o = 0. Other fields are don't-care; they are driven to 0.
- Decode rules
  - LUI: PASSB, imm = U-type.
  - AUIPC: ADD, use_pc, U-type.
  - JAL: is_jump, ADD, use_pc, imm = J-type, reg_we.
  - JALR: is_jump, ADD, imm = I-type, reg_we.
  - BRANCH: is_branch, SUB, imm = B-type, no reg_we.
  - LOAD: is_load, ADD, I-type, reg_we.
  - STORE: is_store, ADD, S-type.
  - OP-IMM and OP: ALU op from funct3/funct7[5]. SUB/SRA only when funct7=0x20.
- reg_we_o is forced to 0 when rd=0.
- Illegal instruction
  - Triggers: unknown opcode, or a funct7 value not defined for OP/shift.
  - Result: illegal_o=1, valid_o=1, all control flags 0, alu_op_o=ADD.
- Immediates are always sign-extended from instr bit 31 to INSTR_SIZE.
- Load-use hazard
  - hazard_stall_o = valid_o & is_load_o & rd_addr_o!=0 & instr_valid_i & !kill_i & (rd_addr_o==rs1 used, or rd_addr_o==rs2 used).
  - rs1 is used by all formats except LUI, AUIPC and JAL.
  - rs2 is used by OP, BRANCH and STORE.
  - Asserts for exactly 1 cycle per hazard, unless stall_i extends it.
  - Fetch holds pc/instr while it is high.
- stall_i and hazard together: stall_i wins; the hazard is re-evaluated next cycle.
- Reset mid-stall or mid-hazard: outputs clear immediately. hazard_stall_o goes to 0 since valid_o=0.

Test Plan:
- Reset, then instr 0x00500093 (addi x1,x0,5) valid -> next cycle: valid_o=1, rd=1, rs1=0, imm_o=5, alu_op_o=0, use_imm_o=1, reg_we_o=1.
- 0x0000A103 (lw x2,0(x1)) then 0x001101B3 (add x3,x2,x1) -> hazard_stall_o=1 for 1 cycle, one bubble (valid_o=0), then add decoded with rs1=2, rs2=1, rd=3, alu_op_o=0.
- 0xFE000CE3 (beq x0,x0,-8) -> imm_o=0xFFFFFFF8, is_branch_o=1, reg_we_o=0, funct3_o=0, alu_op_o=1.
- Valid add held under stall_i=1 for 3 cycles, kill_i=1 in cycle 2 -> bundle held in cycle 1, valid_o=0 after the kill edge.
- 0xFFFFFFFF valid -> illegal_o=1, valid_o=1, reg_we_o=0. Then 0x00000013 (addi x0,x0,0) -> reg_we_o=0, illegal_o=0.
- Async reset asserted between edges during a hazard -> valid_o and hazard_stall_o drop to 0 without waiting for a clock edge.

Source files
------------

// File: rtl/stage_decode.sv
// RV32I decode stage: combinational decode of the fetched word into a registered
// execute bundle, with load-use hazard detection and bubble insertion.
module stage_decode #(
    parameter int INSTR_SIZE = 32,
    parameter int REG_ADDR_W = 5,
    parameter int ALU_OP_W   = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [INSTR_SIZE-1:0] pc_i,
    input  logic [INSTR_SIZE-1:0] instr_i,
    input  logic                  instr_valid_i,
    input  logic                  stall_i,
    input  logic                  kill_i,
    output logic                  hazard_stall_o,
    output logic                  valid_o,
    output logic [INSTR_SIZE-1:0] pc_o,
    output logic [REG_ADDR_W-1:0] rs1_addr_o,
    output logic [REG_ADDR_W-1:0] rs2_addr_o,
    output logic [REG_ADDR_W-1:0] rd_addr_o,
    output logic [INSTR_SIZE-1:0] imm_o,
    output logic [ALU_OP_W-1:0]   alu_op_o,
    output logic [2:0]            funct3_o,
    output logic                  use_imm_o,
    output logic                  use_pc_o,
    output logic                  reg_we_o,
    output logic                  is_load_o,
    output logic                  is_store_o,
    output logic                  is_branch_o,
    output logic                  is_jump_o,
    output logic                  illegal_o
);

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    localparam logic [ALU_OP_W-1:0] ALU_ADD   = ALU_OP_W'(0);
    localparam logic [ALU_OP_W-1:0] ALU_SUB   = ALU_OP_W'(1);
    localparam logic [ALU_OP_W-1:0] ALU_SLL   = ALU_OP_W'(2);
    localparam logic [ALU_OP_W-1:0] ALU_SLT   = ALU_OP_W'(3);
    localparam logic [ALU_OP_W-1:0] ALU_SLTU  = ALU_OP_W'(4);
    localparam logic [ALU_OP_W-1:0] ALU_XOR   = ALU_OP_W'(5);
    localparam logic [ALU_OP_W-1:0] ALU_SRL   = ALU_OP_W'(6);
    localparam logic [ALU_OP_W-1:0] ALU_SRA   = ALU_OP_W'(7);
    localparam logic [ALU_OP_W-1:0] ALU_OR    = ALU_OP_W'(8);
    localparam logic [ALU_OP_W-1:0] ALU_AND   = ALU_OP_W'(9);
    localparam logic [ALU_OP_W-1:0] ALU_PASSB = ALU_OP_W'(10);

    logic [6:0]            w_opcode;
    logic [2:0]            w_funct3;
    logic [6:0]            w_funct7;
    logic [REG_ADDR_W-1:0] w_rs1, w_rs2, w_rd;
    logic [31:0]           w_imm32;
    logic [INSTR_SIZE-1:0] w_imm;
    logic [ALU_OP_W-1:0]   w_alu_op;
    logic                  w_use_imm, w_use_pc, w_reg_we, w_is_load, w_is_store;
    logic                  w_is_branch, w_is_jump, w_illegal, w_rs1_used, w_rs2_used;
    logic                  w_hazard;

    logic                  r_valid, r_use_imm, r_use_pc, r_reg_we, r_is_load;
    logic                  r_is_store, r_is_branch, r_is_jump, r_illegal;
    logic [INSTR_SIZE-1:0] r_pc, r_imm;
    logic [REG_ADDR_W-1:0] r_rs1, r_rs2, r_rd;
    logic [ALU_OP_W-1:0]   r_alu_op;
    logic [2:0]            r_funct3;

    assign w_opcode = instr_i[6:0];
    assign w_funct3 = instr_i[14:12];
    assign w_funct7 = instr_i[31:25];
    assign w_rs1    = REG_ADDR_W'(instr_i[19:15]);
    assign w_rs2    = REG_ADDR_W'(instr_i[24:20]);
    assign w_rd     = REG_ADDR_W'(instr_i[11:7]);

    always_comb begin
        w_imm32     = '0;
        w_alu_op    = ALU_ADD;
        w_use_imm   = 1'b0;
        w_use_pc    = 1'b0;
        w_reg_we    = 1'b0;
        w_is_load   = 1'b0;
        w_is_store  = 1'b0;
        w_is_branch = 1'b0;
        w_is_jump   = 1'b0;
        w_illegal   = 1'b0;
        w_rs1_used  = 1'b1;
        w_rs2_used  = 1'b0;
        case (w_opcode)
            OPC_LUI: begin
                w_imm32    = {instr_i[31:12], 12'h000};
                w_alu_op   = ALU_PASSB;
                w_use_imm  = 1'b1;
                w_reg_we   = 1'b1;
                w_rs1_used = 1'b0;
            end
            OPC_AUIPC: begin
                w_imm32    = {instr_i[31:12], 12'h000};
                w_use_imm  = 1'b1;
                w_use_pc   = 1'b1;
                w_reg_we   = 1'b1;
                w_rs1_used = 1'b0;
            end
            OPC_JAL: begin
                w_imm32    = {{12{instr_i[31]}}, instr_i[19:12], instr_i[20],
                              instr_i[30:21], 1'b0};
                w_use_imm  = 1'b1;
                w_use_pc   = 1'b1;
                w_reg_we   = 1'b1;
                w_is_jump  = 1'b1;
                w_rs1_used = 1'b0;
            end
            OPC_JALR: begin
                w_imm32   = {{20{instr_i[31]}}, instr_i[31:20]};
                w_use_imm = 1'b1;
                w_reg_we  = 1'b1;
                w_is_jump = 1'b1;
            end
            OPC_BRANCH: begin
                w_imm32     = {{20{instr_i[31]}}, instr_i[7], instr_i[30:25],
                               instr_i[11:8], 1'b0};
                w_alu_op    = ALU_SUB;
                w_is_branch = 1'b1;
                w_rs2_used  = 1'b1;
            end
            OPC_LOAD: begin
                w_imm32   = {{20{instr_i[31]}}, instr_i[31:20]};
                w_use_imm = 1'b1;
                w_reg_we  = 1'b1;
                w_is_load = 1'b1;
            end
            OPC_STORE: begin
                w_imm32    = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
                w_use_imm  = 1'b1;
                w_is_store = 1'b1;
                w_rs2_used = 1'b1;
            end
            OPC_OP_IMM, OPC_OP: begin
                w_reg_we = 1'b1;
                if (w_opcode == OPC_OP_IMM) begin
                    w_imm32   = {{20{instr_i[31]}}, instr_i[31:20]};
                    w_use_imm = 1'b1;
                    // Only the shift forms constrain funct7 in OP-IMM.
                    w_illegal = ((w_funct3 == 3'd1) && (w_funct7 != 7'h00)) ||
                                ((w_funct3 == 3'd5) && (w_funct7 != 7'h00) &&
                                 (w_funct7 != 7'h20));
                end else begin
                    w_rs2_used = 1'b1;
                    w_illegal  = !((w_funct7 == 7'h00) ||
                                   ((w_funct7 == 7'h20) &&
                                    ((w_funct3 == 3'd0) || (w_funct3 == 3'd5))));
                end
                case (w_funct3)
                    3'd0: w_alu_op = ((w_opcode == OPC_OP) && (w_funct7 == 7'h20))
                                     ? ALU_SUB : ALU_ADD;
                    3'd1: w_alu_op = ALU_SLL;
                    3'd2: w_alu_op = ALU_SLT;
                    3'd3: w_alu_op = ALU_SLTU;
                    3'd4: w_alu_op = ALU_XOR;
                    3'd5: w_alu_op = (w_funct7 == 7'h20) ? ALU_SRA : ALU_SRL;
                    3'd6: w_alu_op = ALU_OR;
                    default: w_alu_op = ALU_AND;
                endcase
            end
            default: w_illegal = 1'b1;
        endcase
        if (w_illegal) begin
            w_imm32     = '0;
            w_alu_op    = ALU_ADD;
            w_use_imm   = 1'b0;
            w_use_pc    = 1'b0;
            w_reg_we    = 1'b0;
            w_is_load   = 1'b0;
            w_is_store  = 1'b0;
            w_is_branch = 1'b0;
            w_is_jump   = 1'b0;
        end
        if (w_rd == '0) begin
            w_reg_we = 1'b0;
        end
    end

    assign w_imm = INSTR_SIZE'($signed(w_imm32));

    assign w_hazard = r_valid & r_is_load & (r_rd != '0) & instr_valid_i & ~kill_i &
                      (((r_rd == w_rs1) & w_rs1_used) | ((r_rd == w_rs2) & w_rs2_used));

    always_ff @(posedge clk or posedge reset) begin
        if (reset || kill_i || (!stall_i && (!instr_valid_i || w_hazard))) begin
            r_valid     <= 1'b0;
            r_pc        <= '0;
            r_rs1       <= '0;
            r_rs2       <= '0;
            r_rd        <= '0;
            r_imm       <= '0;
            r_alu_op    <= '0;
            r_funct3    <= '0;
            r_use_imm   <= 1'b0;
            r_use_pc    <= 1'b0;
            r_reg_we    <= 1'b0;
            r_is_load   <= 1'b0;
            r_is_store  <= 1'b0;
            r_is_branch <= 1'b0;
            r_is_jump   <= 1'b0;
            r_illegal   <= 1'b0;
        end else if (!stall_i) begin
            r_valid     <= 1'b1;
            r_pc        <= pc_i;
            r_rs1       <= w_rs1;
            r_rs2       <= w_rs2;
            r_rd        <= w_rd;
            r_imm       <= w_imm;
            r_alu_op    <= w_alu_op;
            r_funct3    <= w_funct3;
            r_use_imm   <= w_use_imm;
            r_use_pc    <= w_use_pc;
            r_reg_we    <= w_reg_we;
            r_is_load   <= w_is_load;
            r_is_store  <= w_is_store;
            r_is_branch <= w_is_branch;
            r_is_jump   <= w_is_jump;
            r_illegal   <= w_illegal;
        end
    end

    assign hazard_stall_o = w_hazard;
    assign valid_o        = r_valid;
    assign pc_o           = r_pc;
    assign rs1_addr_o     = r_rs1;
    assign rs2_addr_o     = r_rs2;
    assign rd_addr_o      = r_rd;
    assign imm_o          = r_imm;
    assign alu_op_o       = r_alu_op;
    assign funct3_o       = r_funct3;
    assign use_imm_o      = r_use_imm;
    assign use_pc_o       = r_use_pc;
    assign reg_we_o       = r_reg_we;
    assign is_load_o      = r_is_load;
    assign is_store_o     = r_is_store;
    assign is_branch_o    = r_is_branch;
    assign is_jump_o      = r_is_jump;
    assign illegal_o      = r_illegal;

endmodule

// File: tb/tb_stage_decode.sv
// Bench for stage_decode: directed scenarios plus randomized instruction streams
// compared against a rule-level decode/pipeline model.
module tb_stage_decode;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] pc_i, instr_i;
    logic        instr_valid_i, stall_i, kill_i;
    logic        hazard_stall_o, valid_o;
    logic [31:0] pc_o, imm_o;
    logic [4:0]  rs1_addr_o, rs2_addr_o, rd_addr_o;
    logic [3:0]  alu_op_o;
    logic [2:0]  funct3_o;
    logic        use_imm_o, use_pc_o, reg_we_o, is_load_o, is_store_o;
    logic        is_branch_o, is_jump_o, illegal_o;

    int nchecks = 0;
    int nerr    = 0;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [31:0] imm;
        logic [3:0]  alu;
        logic [2:0]  f3;
        logic        use_imm;
        logic        use_pc;
        logic        we;
        logic        ld;
        logic        sto;
        logic        br;
        logic        jmp;
        logic        ill;
    } bundle_t;

    bundle_t e;
    bundle_t act;

    assign act = {valid_o, pc_o, rs1_addr_o, rs2_addr_o, rd_addr_o, imm_o, alu_op_o,
                  funct3_o, use_imm_o, use_pc_o, reg_we_o, is_load_o, is_store_o,
                  is_branch_o, is_jump_o, illegal_o};

    stage_decode #(
        .INSTR_SIZE(32),
        .REG_ADDR_W(5),
        .ALU_OP_W(4)
    ) dut (
        .clk(clk), .reset(reset), .pc_i(pc_i), .instr_i(instr_i),
        .instr_valid_i(instr_valid_i), .stall_i(stall_i), .kill_i(kill_i),
        .hazard_stall_o(hazard_stall_o), .valid_o(valid_o), .pc_o(pc_o),
        .rs1_addr_o(rs1_addr_o), .rs2_addr_o(rs2_addr_o), .rd_addr_o(rd_addr_o),
        .imm_o(imm_o), .alu_op_o(alu_op_o), .funct3_o(funct3_o),
        .use_imm_o(use_imm_o), .use_pc_o(use_pc_o), .reg_we_o(reg_we_o),
        .is_load_o(is_load_o), .is_store_o(is_store_o), .is_branch_o(is_branch_o),
        .is_jump_o(is_jump_o), .illegal_o(illegal_o)
    );

    always #5 clk = ~clk;

    function automatic bundle_t ref_decode(logic [31:0] ins, logic [31:0] pc);
        bundle_t    b = '0;
        logic [6:0] op = ins[6:0];
        logic [2:0] f3 = ins[14:12];
        logic [6:0] f7 = ins[31:25];
        logic [3:0] base [8] = '{4'd0, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd8, 4'd9};
        logic [31:0] imm_i = {{20{ins[31]}}, ins[31:20]};
        logic [31:0] imm_u = {ins[31:12], 12'h000};
        b.valid = 1'b1;
        b.pc  = pc;
        b.rs1 = ins[19:15];
        b.rs2 = ins[24:20];
        b.rd  = ins[11:7];
        b.f3  = f3;
        case (op)
            7'h37: begin b.imm = imm_u; b.alu = 4'd10; b.use_imm = 1; b.we = 1; end
            7'h17: begin b.imm = imm_u; b.use_imm = 1; b.use_pc = 1; b.we = 1; end
            7'h6F: begin
                b.imm = {{12{ins[31]}}, ins[19:12], ins[20], ins[30:21], 1'b0};
                b.use_imm = 1; b.use_pc = 1; b.we = 1; b.jmp = 1;
            end
            7'h67: begin b.imm = imm_i; b.use_imm = 1; b.we = 1; b.jmp = 1; end
            7'h63: begin
                b.imm = {{20{ins[31]}}, ins[7], ins[30:25], ins[11:8], 1'b0};
                b.alu = 4'd1; b.br = 1;
            end
            7'h03: begin b.imm = imm_i; b.use_imm = 1; b.we = 1; b.ld = 1; end
            7'h23: begin
                b.imm = {{20{ins[31]}}, ins[31:25], ins[11:7]};
                b.use_imm = 1; b.sto = 1;
            end
            7'h13: begin
                b.imm = imm_i; b.use_imm = 1; b.we = 1;
                b.alu = base[f3];
                if (f3 == 3'd5 && f7 == 7'h20) b.alu = 4'd7;
                if ((f3 == 3'd1 && f7 != 7'h00) ||
                    (f3 == 3'd5 && f7 != 7'h00 && f7 != 7'h20)) b.ill = 1;
            end
            7'h33: begin
                b.we = 1;
                b.alu = base[f3];
                if (f7 == 7'h20 && f3 == 3'd0) b.alu = 4'd1;
                if (f7 == 7'h20 && f3 == 3'd5) b.alu = 4'd7;
                if (!(f7 == 7'h00 || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5)))) b.ill = 1;
            end
            default: b.ill = 1;
        endcase
        if (b.ill) begin
            b.imm = '0; b.alu = '0; b.use_imm = 0; b.use_pc = 0; b.we = 0;
            b.ld = 0; b.sto = 0; b.br = 0; b.jmp = 0;
        end
        if (b.rd == 5'd0) b.we = 0;
        return b;
    endfunction

    function automatic logic exp_hazard(bundle_t r, logic [31:0] ins, logic iv, logic kl);
        logic [6:0] op = ins[6:0];
        logic uses1 = !(op == 7'h37 || op == 7'h17 || op == 7'h6F);
        logic uses2 = (op == 7'h33 || op == 7'h63 || op == 7'h23);
        return r.valid && r.ld && (r.rd != 5'd0) && iv && !kl &&
               ((uses1 && r.rd == ins[19:15]) || (uses2 && r.rd == ins[24:20]));
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [6:0]  ops [9] = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33};
        logic [31:0] w = $urandom;
        w[6:0]   = ops[$urandom_range(0, 8)];
        w[11:7]  = 5'($urandom_range(0, 3));
        w[19:15] = 5'($urandom_range(0, 3));
        w[24:20] = 5'($urandom_range(0, 3));
        if (w[6:0] == 7'h33 || w[6:0] == 7'h13) begin
            case ($urandom_range(0, 3))
                0, 1:    w[31:25] = 7'h00;
                2:       w[31:25] = 7'h20;
                default: ;
            endcase
        end
        if ($urandom_range(0, 19) == 0) w[6:0] = 7'($urandom);
        return w;
    endfunction

    task automatic drive(input logic [31:0] pc, input logic [31:0] ins,
                         input logic v, input logic st, input logic kl);
        pc_i = pc; instr_i = ins; instr_valid_i = v; stall_i = st; kill_i = kl;
    endtask

    // Advances one clock and the reference pipeline register alongside it.
    task automatic tick();
        logic hz;
        hz = exp_hazard(e, instr_i, instr_valid_i, kill_i);
        @(posedge clk);
        if (reset || kill_i) e = '0;
        else if (stall_i) e = e;
        else if (!instr_valid_i || hz) e = '0;
        else e = ref_decode(instr_i, pc_i);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        drive(32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        e = '0;
        #2;
        nchecks++;
        if (act !== '0) begin
            nerr++; $display("FAIL reset_bundle got=%h want=0", act);
        end
        nchecks++;
        if (hazard_stall_o !== 1'b0) begin
            nerr++; $display("FAIL reset_hazard got=%b want=0", hazard_stall_o);
        end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_addi();
        drive(32'h100, 32'h00500093, 1'b1, 1'b0, 1'b0);
        tick();
        nchecks++;
        if ({valid_o, rd_addr_o, rs1_addr_o, imm_o, alu_op_o, use_imm_o, reg_we_o} !==
            {1'b1, 5'd1, 5'd0, 32'd5, 4'd0, 1'b1, 1'b1}) begin
            nerr++; $display("FAIL addi got=%h want=%h",
                {valid_o, rd_addr_o, rs1_addr_o, imm_o, alu_op_o, use_imm_o, reg_we_o},
                {1'b1, 5'd1, 5'd0, 32'd5, 4'd0, 1'b1, 1'b1});
        end
        nchecks++;
        if (act !== e) begin
            nerr++; $display("FAIL addi_model got=%h want=%h", act, e);
        end
    endtask

    task automatic test_load_use();
        drive(32'h104, 32'h0000A103, 1'b1, 1'b0, 1'b0);
        tick();
        drive(32'h108, 32'h001101B3, 1'b1, 1'b0, 1'b0);
        #1;
        nchecks++;
        if (hazard_stall_o !== 1'b1) begin
            nerr++; $display("FAIL lu_hazard got=%b want=1", hazard_stall_o);
        end
        tick();
        nchecks++;
        if ({valid_o, hazard_stall_o} !== 2'b00) begin
            nerr++; $display("FAIL lu_bubble got=%b want=00", {valid_o, hazard_stall_o});
        end
        tick();
        nchecks++;
        if ({valid_o, pc_o, rs1_addr_o, rs2_addr_o, rd_addr_o, alu_op_o, reg_we_o} !==
            {1'b1, 32'h108, 5'd2, 5'd1, 5'd3, 4'd0, 1'b1}) begin
            nerr++; $display("FAIL lu_add got=%h want=%h",
                {valid_o, pc_o, rs1_addr_o, rs2_addr_o, rd_addr_o, alu_op_o, reg_we_o},
                {1'b1, 32'h108, 5'd2, 5'd1, 5'd3, 4'd0, 1'b1});
        end
    endtask

    task automatic test_branch();
        drive(32'h10C, 32'hFE000CE3, 1'b1, 1'b0, 1'b0);
        tick();
        nchecks++;
        if ({imm_o, is_branch_o, reg_we_o, funct3_o, alu_op_o, valid_o} !==
            {32'hFFFFFFF8, 1'b1, 1'b0, 3'd0, 4'd1, 1'b1}) begin
            nerr++; $display("FAIL beq got=%h want=%h",
                {imm_o, is_branch_o, reg_we_o, funct3_o, alu_op_o, valid_o},
                {32'hFFFFFFF8, 1'b1, 1'b0, 3'd0, 4'd1, 1'b1});
        end
    endtask

    task automatic test_stall_kill();
        bundle_t held;
        drive(32'h200, 32'h001101B3, 1'b1, 1'b0, 1'b0);
        tick();
        held = e;
        drive(32'h204, 32'h00500093, 1'b1, 1'b1, 1'b0);
        tick();
        nchecks++;
        if (act !== held || valid_o !== 1'b1) begin
            nerr++; $display("FAIL stall_hold got=%h want=%h", act, held);
        end
        drive(32'h204, 32'h00500093, 1'b1, 1'b1, 1'b1);
        tick();
        nchecks++;
        if (act !== '0) begin
            nerr++; $display("FAIL kill_under_stall got=%h want=0", act);
        end
        drive(32'h204, 32'h00500093, 1'b1, 1'b1, 1'b0);
        tick();
        nchecks++;
        if (valid_o !== 1'b0) begin
            nerr++; $display("FAIL stall_bubble got=%b want=0", valid_o);
        end
        drive(32'h204, 32'h00500093, 1'b0, 1'b0, 1'b0);
        tick();
    endtask

    task automatic test_illegal();
        drive(32'h300, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b0);
        tick();
        nchecks++;
        if ({illegal_o, valid_o, reg_we_o, is_load_o, is_store_o, is_branch_o, is_jump_o,
             alu_op_o} !== {1'b1, 1'b1, 5'b0, 4'd0}) begin
            nerr++; $display("FAIL illegal got=%h want=%h",
                {illegal_o, valid_o, reg_we_o, is_load_o, is_store_o, is_branch_o,
                 is_jump_o, alu_op_o}, {1'b1, 1'b1, 5'b0, 4'd0});
        end
        drive(32'h304, 32'h00000013, 1'b1, 1'b0, 1'b0);
        tick();
        nchecks++;
        if ({valid_o, reg_we_o, illegal_o} !== 3'b100) begin
            nerr++; $display("FAIL nop_x0 got=%b want=100", {valid_o, reg_we_o, illegal_o});
        end
    endtask

    task automatic test_async_reset();
        drive(32'h400, 32'h0000A103, 1'b1, 1'b0, 1'b0);
        tick();
        drive(32'h404, 32'h001101B3, 1'b1, 1'b0, 1'b0);
        #1;
        nchecks++;
        if (hazard_stall_o !== 1'b1) begin
            nerr++; $display("FAIL ar_hazard_pre got=%b want=1", hazard_stall_o);
        end
        #2 reset = 1'b1;
        #1;
        nchecks++;
        if ({valid_o, hazard_stall_o} !== 2'b00 || act !== '0) begin
            nerr++; $display("FAIL async_reset got=%b want=00", {valid_o, hazard_stall_o});
        end
        e = '0;
        #1 reset = 1'b0;
    endtask

    task automatic test_random();
        for (int i = 0; i < 500; i++) begin
            drive($urandom & 32'hFFFF_FFFC, rand_instr(),
                  ($urandom_range(0, 9) != 0), ($urandom_range(0, 4) == 0),
                  ($urandom_range(0, 9) == 0));
            #1;
            nchecks++;
            if (hazard_stall_o !== exp_hazard(e, instr_i, instr_valid_i, kill_i)) begin
                nerr++; $display("FAIL rand_hazard i=%0d got=%b want=%b", i, hazard_stall_o,
                                 exp_hazard(e, instr_i, instr_valid_i, kill_i));
            end
            tick();
            nchecks++;
            if (act !== e) begin
                nerr++; $display("FAIL rand_bundle i=%0d instr=%h got=%h want=%h",
                                 i, instr_i, act, e);
            end
        end
    endtask

    initial begin
        test_reset();
        test_addi();
        test_load_use();
        test_branch();
        test_stall_kill();
        test_illegal();
        test_async_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", nchecks, nerr);
        $finish;
    end

endmodule
